// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM state type and default sizing constants for sort_sched
package sort_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;
    localparam int DEF_DEPTH          = 8;
    localparam int DEF_WIDTH          = 32;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick starting one past last, one-hot grant plus index
// ports: req (requests), last (previous owner), gnt (one-hot), id (winner index)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      id
);
    logic [IW-1:0] k;
    logic          found;
    always_comb begin
        gnt   = '0;
        id    = '0;
        k     = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = IW'((int'(last) + i) % NUM_REQ);
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                id     = k;
            end
        end
    end
endmodule

// File: rtl/sort_sched.sv
// sort_sched: shares one sort engine among NUM_REQ requesters (load, sort, drain)
// ports: clk, rst (sync, active-high); req/gnt arbitration; in_valid/in_data/in_ready load;
//        srt_start/srt_data_in/srt_data_out/srt_done engine; out_valid/out_data/out_last/
//        out_id/out_ready result stream; err WAIT timeout pulse (only with SORT_SCHED_TIMEOUT_EN)
module sort_sched
    import sort_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       srt_start,
    output logic [DEPTH*WIDTH-1:0]     srt_data_in,
    input  logic [DEPTH*WIDTH-1:0]     srt_data_out,
    input  logic                       srt_done,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
`ifdef SORT_SCHED_TIMEOUT_EN
    output logic                       err,
`endif
    input  logic                       out_ready
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DEPTH);
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          last_owner, owner, arb_id;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [DEPTH*WIDTH-1:0] job, res;
    logic                   done_q, last_word;
`ifdef SORT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]          tmo;
`endif
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req (req),
        .last(last_owner),
        .gnt (arb_gnt),
        .id  (arb_id)
    );
    assign last_word   = cnt == CW'(DEPTH - 1);
    assign in_ready    = state == S_LOAD;
    assign srt_start   = state == S_START;
    assign out_valid   = state == S_DRAIN;
    assign out_last    = out_valid && last_word;
    assign out_id      = out_valid ? owner : '0;
    assign out_data    = out_valid ? res[int'(cnt)*WIDTH +: WIDTH] : '0;
    assign srt_data_in = job;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_owner <= IW'(NUM_REQ - 1);
            owner      <= '0;
            gnt        <= '0;
            done_q     <= 1'b0;
            job        <= '0;
            res        <= '0;
`ifdef SORT_SCHED_TIMEOUT_EN
            tmo        <= '0;
            err        <= 1'b0;
`endif
        end else begin
            done_q <= srt_done;
`ifdef SORT_SCHED_TIMEOUT_EN
            err    <= 1'b0;
`endif
            case (state)
                S_IDLE: if (|req) begin
                    gnt   <= arb_gnt;
                    owner <= arb_id;
                    cnt   <= '0;
                    state <= S_LOAD;
                end
                S_LOAD: if (in_valid) begin
                    job[int'(cnt)*WIDTH +: WIDTH] <= in_data;
                    cnt   <= last_word ? '0 : cnt + 1'b1;
                    state <= last_word ? S_START : S_LOAD;
                end
                S_START: begin
`ifdef SORT_SCHED_TIMEOUT_EN
                    tmo   <= '0;
`endif
                    state <= S_WAIT;
                end
                // only a fresh rising edge counts; a level already high on entry is stale
                S_WAIT: if (srt_done && !done_q) begin
                    res   <= srt_data_out;
                    cnt   <= '0;
                    state <= S_DRAIN;
                end
`ifdef SORT_SCHED_TIMEOUT_EN
                else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    err        <= 1'b1;
                    gnt        <= '0;
                    last_owner <= owner;
                    state      <= S_IDLE;
                end else begin
                    tmo <= tmo + 1'b1;
                end
`endif
                S_DRAIN: if (out_ready) begin
                    cnt <= last_word ? '0 : cnt + 1'b1;
                    if (last_word) begin
                        gnt        <= '0;
                        last_owner <= owner;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_sched.sv
// tb_sort_sched: randomized and directed checks of sort_sched against a queue-sort model
module tb_sort_sched;
    localparam int NR = 2, D = 8, W = 32, TO = 16;
    logic            clk = 1'b0, rst = 1'b1;
    logic [NR-1:0]   req = '0, gnt;
    logic            in_valid = 1'b0, in_ready;
    logic [W-1:0]    in_data = '0;
    logic            srt_start, srt_done = 1'b0;
    logic [D*W-1:0]  srt_data_in, srt_data_out = '0;
    logic            out_valid, out_last, out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic [$clog2(NR)-1:0] out_id;
    logic            err;
    int n_assert = 0, n_fail = 0, lo = NR - 1, ovl = 0;
    logic [W-1:0] words [D];

    sort_sched #(.NUM_REQ(NR), .DEPTH(D), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .srt_start(srt_start), .srt_data_in(srt_data_in),
        .srt_data_out(srt_data_out), .srt_done(srt_done),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_id(out_id),
`ifdef SORT_SCHED_TIMEOUT_EN
        .err(err),
`endif
        .out_ready(out_ready)
    );
`ifndef SORT_SCHED_TIMEOUT_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(negedge clk) if (in_ready && out_valid) ovl++;

    task automatic chk(input string tag, input logic [D*W-1:0] obs, input logic [D*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NR-1:0] rq);
        for (int k = 1; k <= NR; k++)
            if (rq[(lo + k) % NR]) return (lo + k) % NR;
        return 0;
    endfunction

    task automatic fill_random;
        for (int i = 0; i < D; i++) words[i] = $urandom;
    endtask

    task automatic run_job(input logic [NR-1:0] rq, input int gap, input int rdy,
                           input int eng, input bit glitch, input bit hold);
        logic [W-1:0]   q[$];
        logic [D*W-1:0] pk, sp;
        int own, n, i;
        own = pick(rq);
        req = rq;
        pk = '0;
        for (int j = 0; j < D; j++) begin
            pk[j*W +: W] = words[j];
            q.push_back(words[j]);
        end
        q.sort();
        for (int j = 0; j < D; j++) sp[j*W +: W] = q[j];
        n = 0;
        while (gnt == '0 && n < 20) begin step; n++; end
        chk("grant", gnt, (1 << own));
        chk("load_ready", in_ready, 1);
        for (int j = 0; j < D; j++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap; g++) begin
                in_valid = 1'b0;
                step;
            end
            in_valid = 1'b1;
            in_data  = words[j];
            if (glitch && j == D - 1) begin
                srt_done     = 1'b1;
                srt_data_out = '1;
            end
            step;
        end
        in_valid = 1'b0;
        chk("start_pulse", srt_start, 1);
        chk("job_vector", srt_data_in, pk);
        step;
        chk("start_single", srt_start, 0);
        if (glitch) begin
            repeat (3) step;
            chk("stale_done_ignored", out_valid, 0);
            srt_done = 1'b0;
            step;
        end
        repeat (eng) step;
        srt_data_out = sp;
        srt_done     = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin step; n++; end
        chk("result_valid", out_valid, 1);
        i = 0;
        n = 0;
        while (i < D && n < 200) begin
            out_ready = $urandom_range(99) < rdy;
            chk("out_data", out_data, q[i]);
            chk("out_last", out_last, (i == D - 1));
            chk("out_id", out_id, own);
            if (out_ready) i++;
            step;
            n++;
        end
        chk("drain_count", i, D);
        out_ready = 1'b0;
        srt_done  = 1'b0;
        lo = own;
        chk("gnt_idle", gnt, 0);
        chk("valid_idle", out_valid, 0);
        if (!hold) req = '0;
    endtask

    initial begin
        step;
        step;
        chk("rst_gnt", gnt, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_start", srt_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        step;
        // directed job with known data and 20-cycle engine
        words = '{5, 3, 8, 1, 7, 2, 6, 4};
        run_job(2'b01, 0, 100, 20, 1'b0, 1'b0);
        // both requesting continuously: alternation from a fresh reset
        rst = 1'b1; step; rst = 1'b0; lo = NR - 1; step;
        for (int j = 0; j < 4; j++) begin
            fill_random;
            run_job(2'b11, 0, 100, 2, 1'b0, j < 3);
        end
        // input gaps and output backpressure
        for (int j = 0; j < 4; j++) begin
            fill_random;
            run_job(NR'($urandom_range(1, 3)), 40, 50, $urandom_range(1, 6), 1'b0, 1'b0);
        end
        // done already high when WAIT is entered
        fill_random;
        run_job(2'b10, 0, 100, 3, 1'b1, 1'b0);
        // reset in the middle of a load
        fill_random;
        req = 2'b01;
        begin
            int n = 0;
            while (gnt == '0 && n < 20) begin step; n++; end
        end
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data  = words[j];
            step;
        end
        rst = 1'b1; in_valid = 1'b0; req = '0;
        step;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_start", srt_start, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_id", out_id, 0);
        rst = 1'b0; lo = NR - 1;
        step;
        run_job(2'b11, 20, 70, 4, 1'b0, 1'b0);
`ifdef SORT_SCHED_TIMEOUT_EN
        begin
            int e = 0, n = 0;
            fill_random;
            req = 2'b01;
            while (gnt == '0 && n < 20) begin step; n++; end
            for (int j = 0; j < D; j++) begin
                in_valid = 1'b1;
                in_data  = words[j];
                step;
            end
            in_valid = 1'b0;
            chk("to_start", srt_start, 1);
            for (int j = 0; j < TO; j++) begin
                step;
                if (err || out_valid) e++;
            end
            chk("to_quiet", e, 0);
            step;
            chk("to_err", err, 1);
            chk("to_gnt", gnt, 0);
            chk("to_out_valid", out_valid, 0);
            req = '0;
            step;
            chk("to_err_pulse", err, 0);
            lo = 0;
        end
`endif
        chk("ready_valid_exclusive", ovl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
